// File: rtl/firebird7_in_gate1_tessent_tdr_red_cfg.sv
// IJTAG test data register with a shift stage, an update stage, a registered update strobe,
// an optional sticky update lock and a retimed scan-out taken from a transparent-low latch.
module firebird7_in_gate1_tessent_tdr_red_cfg #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    parameter int               CAPTURE_SRC = 1,
    parameter int               LOCK_EN     = 0
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_si,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    output logic             ijtag_so,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             update_pulse,
    output logic             locked
);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] upd;
    logic [WIDTH-1:0] cap_val;
    logic             pulse_q;
    logic             lock_q;
    logic             so_lat;
    logic             accept;
    logic             lock_set;

    // Readback configuration captures the update stage instead of the external bus.
    assign cap_val  = (CAPTURE_SRC != 0) ? data_in : upd;

    // Update is only honoured when no capture or shift competes for the same edge.
    assign accept   = ijtag_sel & ijtag_ue & ~ijtag_ce & ~ijtag_se & ~lock_q;
    assign lock_set = (LOCK_EN != 0) & accept & sr[WIDTH-1];

    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            sr <= RESET_VALUE;
        end else if (ijtag_sel) begin
            if (ijtag_ce) begin
                sr <= cap_val;
            end else if (ijtag_se) begin
                sr <= {ijtag_si, sr[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            upd     <= RESET_VALUE;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= accept;
            if (accept) begin
                upd <= sr;
            end
        end
    end

    // The lock is sticky: only reset can release it.
    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            lock_q <= 1'b0;
        end else if (lock_set) begin
            lock_q <= 1'b1;
        end
    end

    // Scan-out retiming: opens while tck is low so the next stage sees data on the falling edge.
    always_latch begin
        if (!ijtag_reset) begin
            so_lat <= RESET_VALUE[0];
        end else if (!ijtag_tck) begin
            so_lat <= sr[0];
        end
    end

    assign ijtag_so     = so_lat;
    assign data_out     = upd;
    assign update_pulse = pulse_q;
    assign locked       = lock_q;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_red_cfg.sv
// Bench for the IJTAG TDR: two configurations driven in parallel (external capture without lock,
// readback capture with lock) compared every cycle against a bit-level reference model.
module tb_firebird7_in_gate1_tessent_tdr_red_cfg;

    logic       tck;
    logic       rst_n;
    logic       sel, si, ce, se, ue;
    logic [7:0] din;
    logic       so   [2];
    logic [7:0] dout [2];
    logic       up   [2];
    logic       lk   [2];

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [7:0] m_sr   [2];
    logic [7:0] m_upd  [2];
    logic       m_lock [2];
    logic       m_pulse[2];
    logic [7:0] m_rv   [2];
    bit         m_cap  [2];
    bit         m_lken [2];

    firebird7_in_gate1_tessent_tdr_red_cfg #(
        .WIDTH(8), .RESET_VALUE(8'hA5), .CAPTURE_SRC(1), .LOCK_EN(0)
    ) dut_a (
        .ijtag_tck(tck), .ijtag_reset(rst_n), .ijtag_sel(sel), .ijtag_si(si),
        .ijtag_ce(ce), .ijtag_se(se), .ijtag_ue(ue), .ijtag_so(so[0]),
        .data_in(din), .data_out(dout[0]), .update_pulse(up[0]), .locked(lk[0])
    );

    firebird7_in_gate1_tessent_tdr_red_cfg #(
        .WIDTH(8), .CAPTURE_SRC(0), .LOCK_EN(1)
    ) dut_b (
        .ijtag_tck(tck), .ijtag_reset(rst_n), .ijtag_sel(sel), .ijtag_si(si),
        .ijtag_ce(ce), .ijtag_se(se), .ijtag_ue(ue), .ijtag_so(so[1]),
        .data_in(din), .data_out(dout[1]), .update_pulse(up[1]), .locked(lk[1])
    );

    initial begin
        tck = 1'b0;
        forever #5 tck = ~tck;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_sr[i]    = m_rv[i];
            m_upd[i]   = m_rv[i];
            m_lock[i]  = 1'b0;
            m_pulse[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic       acc;
        logic [7:0] old_sr;
        for (int i = 0; i < 2; i++) begin
            acc    = sel && ue && !ce && !se && !m_lock[i];
            old_sr = m_sr[i];
            if (sel && ce)
                m_sr[i] = m_cap[i] ? din : m_upd[i];
            else if (sel && se)
                m_sr[i] = (old_sr >> 1) + (si ? 8'h80 : 8'h00);
            if (acc) begin
                m_upd[i] = old_sr;
                if (m_lken[i] && old_sr >= 8'h80) m_lock[i] = 1'b1;
            end
            m_pulse[i] = acc;
        end
    endtask

    task automatic chk_regs();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("data_out[%0d]", i), 64'(dout[i]), 64'(m_upd[i]));
            chk($sformatf("update_pulse[%0d]", i), 64'(up[i]), 64'(m_pulse[i]));
            chk($sformatf("locked[%0d]", i), 64'(lk[i]), 64'(m_lock[i]));
        end
    endtask

    task automatic chk_so();
        for (int i = 0; i < 2; i++)
            chk($sformatf("so[%0d]", i), 64'(so[i]), 64'(m_sr[i][0]));
    endtask

    // One tck period: drive just after the falling edge, check regs after the rising edge
    // and scan-out after the falling edge.
    task automatic cyc(input logic s, input logic c, input logic sh, input logic u,
                       input logic d, input logic [7:0] di);
        sel = s; ce = c; se = sh; ue = u; si = d; din = di;
        @(posedge tck);
        model_edge();
        #1 chk_regs();
        @(negedge tck);
        #1 chk_so();
    endtask

    task automatic shift_byte(input logic [7:0] v);
        for (int k = 0; k < 8; k++) cyc(1'b1, 1'b0, 1'b1, 1'b0, v[k], 8'h00);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_regs();
        @(posedge tck);
        #1 chk_regs();
        @(negedge tck);
        #1 chk_so();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] e;
        m_rv[0] = 8'hA5; m_cap[0] = 1'b1; m_lken[0] = 1'b0;
        m_rv[1] = 8'h00; m_cap[1] = 1'b0; m_lken[1] = 1'b1;
        rst_n = 1'b0;
        sel = 0; si = 0; ce = 0; se = 0; ue = 0; din = 8'h00;
        model_reset();
        @(negedge tck);
        #1;
        chk("rst_dout_a", 64'(dout[0]), 64'h A5);
        chk("rst_so_a", 64'(so[0]), 64'h1);
        chk("rst_lock_a", 64'(lk[0]), 64'h0);
        chk("rst_pulse_a", 64'(up[0]), 64'h0);
        chk("rst_dout_b", 64'(dout[1]), 64'h00);
        chk_regs();
        chk_so();
        rst_n = 1'b1;

        // shift 3C in and update
        shift_byte(8'h3C);
        cyc(1, 0, 0, 1, 0, 8'h00);
        chk("upd3c_dout", 64'(dout[0]), 64'h3C);
        chk("upd3c_pulse", 64'(up[0]), 64'h1);
        cyc(1, 0, 0, 0, 0, 8'h00);
        chk("upd3c_pulse_drop", 64'(up[0]), 64'h0);

        // external capture of 81, scan it out
        e = 8'h81;
        cyc(1, 1, 0, 0, 0, 8'h81);
        chk("cap81_so0", 64'(so[0]), 64'(e[0]));
        for (int k = 1; k < 8; k++) begin
            cyc(1, 0, 1, 0, 0, 8'h00);
            chk($sformatf("cap81_so%0d", k), 64'(so[0]), 64'(e[k]));
        end
        cyc(1, 0, 1, 0, 0, 8'h00);

        // readback capture on the second instance
        e = 8'h5A;
        shift_byte(8'h5A);
        cyc(1, 0, 0, 1, 0, 8'h00);
        chk("rb_dout", 64'(dout[1]), 64'h5A);
        cyc(1, 1, 0, 0, 0, 8'h00);
        chk("rb_so0", 64'(so[1]), 64'(e[0]));
        for (int k = 1; k < 8; k++) begin
            cyc(1, 0, 1, 0, 0, 8'h00);
            chk($sformatf("rb_so%0d", k), 64'(so[1]), 64'(e[k]));
        end

        // lock on MSB, then rejected update, then reset releases
        shift_byte(8'h80);
        cyc(1, 0, 0, 1, 0, 8'h00);
        chk("lock_set", 64'(lk[1]), 64'h1);
        chk("lock_dout", 64'(dout[1]), 64'h80);
        shift_byte(8'h11);
        cyc(1, 0, 0, 1, 0, 8'h00);
        chk("locked_dout", 64'(dout[1]), 64'h80);
        chk("locked_pulse", 64'(up[1]), 64'h0);
        chk("locked_so_shift", 64'(so[1]), 64'h1);
        do_reset();
        chk("lock_cleared", 64'(lk[1]), 64'h0);
        chk("lock_rst_dout", 64'(dout[1]), 64'h00);

        // update enable competing with shift / capture, and deselected update
        shift_byte(8'hC3);
        cyc(1, 0, 1, 1, 1, 8'h00);
        chk("ue_se_dout", 64'(dout[0]), 64'hA5);
        chk("ue_se_pulse", 64'(up[0]), 64'h0);
        cyc(1, 1, 0, 1, 0, 8'h77);
        chk("ue_ce_pulse", 64'(up[0]), 64'h0);
        cyc(0, 0, 0, 1, 0, 8'h00);
        chk("nosel_dout", 64'(dout[0]), 64'hA5);
        chk("nosel_pulse", 64'(up[0]), 64'h0);

        // back-to-back accepted updates
        cyc(1, 0, 0, 1, 0, 8'h00);
        chk("b2b_pulse1", 64'(up[0]), 64'h1);
        cyc(1, 0, 0, 1, 0, 8'h00);
        chk("b2b_pulse2", 64'(up[0]), 64'h1);

        // randomized traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 49) == 0)
                do_reset();
            else
                cyc(($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
                    1'($urandom), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
